// File: rtl/montgomery_reduce_pipe.sv
// Multi-lane 3-stage elastic Montgomery reducer: mode 0 = Dilithium (R=2^32), mode 1 = Kyber (R=2^16).
// Define MONT_FINAL_CORRECT_EN to fold every result into the canonical range [0, Q).
module montgomery_reduce_pipe #(
    parameter int unsigned LANES = 4,
    parameter int unsigned IN_W  = 64,
    parameter int unsigned OUT_W = 32,
    parameter int unsigned TAG_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rstn_i,
    input  logic                   flush_i,
    input  logic                   in_valid_i,
    output logic                   in_ready_o,
    input  logic                   mode_i,
    input  logic [LANES*IN_W-1:0]  data_i,
    input  logic [TAG_W-1:0]       tag_i,
    output logic                   out_valid_o,
    input  logic                   out_ready_i,
    output logic [LANES*OUT_W-1:0] data_o,
    output logic [TAG_W-1:0]       tag_o,
    output logic                   mode_o
);
    localparam int unsigned TW = 32;

`ifdef MONT_FINAL_CORRECT_EN
    localparam logic [OUT_W-1:0] DIL_Q = 32'd8380417;
    localparam logic [OUT_W-1:0] KYB_Q = 32'd3329;
`endif

    // QINV = 58728449 = 2^25 + 2^24 + 2^23 + 2^13 + 1 (mod 2^32)
    function automatic logic [31:0] dil_qinv(input logic [31:0] x);
        return x + (x << 13) + (x << 23) + (x << 24) + (x << 25);
    endfunction

    // QINV = 62209 = 2^15 + 2^14 + 2^13 + 2^12 + 2^9 + 2^8 + 1 (mod 2^16)
    function automatic logic [15:0] kyb_qinv(input logic [15:0] x);
        return x + (x << 8) + (x << 9) + (x << 12) + (x << 13) + (x << 14) + (x << 15);
    endfunction

    // Q = 8380417 = 2^23 - 2^13 + 1
    function automatic logic [63:0] dil_q(input logic [63:0] x);
        return (x << 23) - (x << 13) + x;
    endfunction

    // Q = 3329 = 2^11 + 2^10 + 2^8 + 1
    function automatic logic [63:0] kyb_q(input logic [63:0] x);
        return (x << 11) + (x << 10) + (x << 8) + x;
    endfunction

    logic v1, v2, v3;
    logic adv1, adv2, adv3;

    // A stage moves forward when it is empty or its successor moves forward.
    assign adv3        = !v3 || out_ready_i;
    assign adv2        = !v2 || adv3;
    assign adv1        = !v1 || adv2;
    assign in_ready_o  = adv1;
    assign out_valid_o = v3;

    logic [IN_W-1:0]  s1_a   [LANES];
    logic [TW-1:0]    s1_t   [LANES];
    logic             s1_mode;
    logic [TAG_W-1:0] s1_tag;
    logic [IN_W-1:0]  s2_a   [LANES];
    logic [IN_W-1:0]  s2_tq  [LANES];
    logic             s2_mode;
    logic [TAG_W-1:0] s2_tag;

    logic [IN_W-1:0]  a_d    [LANES];
    logic [15:0]      kt_d   [LANES];
    logic [TW-1:0]    t_d    [LANES];
    logic [IN_W-1:0]  text_d [LANES];
    logic [IN_W-1:0]  tq_d   [LANES];
    logic [IN_W-1:0]  diff_d [LANES];
    logic [OUT_W-1:0] r_d    [LANES];

    // Stage 1: t = a*QINV truncated to the Montgomery word; Kyber t is kept sign-extended.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            a_d[k]  = data_i[k*IN_W +: IN_W];
            kt_d[k] = kyb_qinv(a_d[k][15:0]);
            t_d[k]  = mode_i ? {{16{kt_d[k][15]}}, kt_d[k]} : dil_qinv(a_d[k][31:0]);
        end
    end

    // Stage 2: t*Q on the sign-extended t.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            text_d[k] = {{32{s1_t[k][TW-1]}}, s1_t[k]};
            tq_d[k]   = s1_mode ? kyb_q(text_d[k]) : dil_q(text_d[k]);
        end
    end

    // Stage 3: (a - t*Q) >>> R; Kyber uses 32-bit wrapping arithmetic on the low word only.
    always_comb begin
        for (int k = 0; k < LANES; k++) begin
            diff_d[k] = s2_a[k] - s2_tq[k];
            r_d[k]    = s2_mode ? 32'($signed(diff_d[k][31:0]) >>> 16)
                                : 32'($signed(diff_d[k]) >>> 32);
`ifdef MONT_FINAL_CORRECT_EN
            if (r_d[k][OUT_W-1]) begin
                r_d[k] = r_d[k] + (s2_mode ? KYB_Q : DIL_Q);
            end
`endif
        end
    end

    // Stage valids; flush wins over every advance.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (flush_i) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else begin
            if (adv1) v1 <= in_valid_i;
            if (adv2) v2 <= v1;
            if (adv3) v3 <= v2;
        end
    end

    // Payload registers load only when their stage takes a valid transaction.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int k = 0; k < LANES; k++) begin
                s1_a[k]  <= '0;
                s1_t[k]  <= '0;
                s2_a[k]  <= '0;
                s2_tq[k] <= '0;
            end
            s1_mode <= 1'b0;
            s1_tag  <= '0;
            s2_mode <= 1'b0;
            s2_tag  <= '0;
            data_o  <= '0;
            tag_o   <= '0;
            mode_o  <= 1'b0;
        end else begin
            if (adv1 && in_valid_i) begin
                s1_a    <= a_d;
                s1_t    <= t_d;
                s1_mode <= mode_i;
                s1_tag  <= tag_i;
            end
            if (adv2 && v1) begin
                s2_a    <= s1_a;
                s2_tq   <= tq_d;
                s2_mode <= s1_mode;
                s2_tag  <= s1_tag;
            end
            if (adv3 && v2) begin
                for (int k = 0; k < LANES; k++) begin
                    data_o[k*OUT_W +: OUT_W] <= r_d[k];
                end
                tag_o  <= s2_tag;
                mode_o <= s2_mode;
            end
        end
    end

endmodule

// File: tb/tb_montgomery_reduce_pipe.sv
// Table-driven bench for montgomery_reduce_pipe with a scoreboard and directed flush/reset/backpressure sequences.
// Expectations follow MONT_FINAL_CORRECT_EN the same way the design does.
module tb_montgomery_reduce_pipe;
    localparam int unsigned LANES = 4;
    localparam int unsigned IN_W  = 64;
    localparam int unsigned OUT_W = 32;
    localparam int unsigned TAG_W = 8;
    localparam int unsigned DW    = LANES * OUT_W;

`ifdef MONT_FINAL_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    typedef struct packed {
        logic             mode;
        logic [TAG_W-1:0] tag;
        logic [DW-1:0]    data;
    } exp_t;

    typedef struct {
        logic                  mode;
        logic [LANES*IN_W-1:0] din;
        logic [DW-1:0]         dexp;
    } vec_t;

    logic                  clk = 1'b0;
    logic                  rstn = 1'b0;
    logic                  flush = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic                  mode = 1'b0;
    logic [LANES*IN_W-1:0] data_in = '0;
    logic [TAG_W-1:0]      tag_in = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [DW-1:0]         data_out;
    logic [TAG_W-1:0]      tag_out;
    logic                  mode_out;

    montgomery_reduce_pipe #(
        .LANES(LANES), .IN_W(IN_W), .OUT_W(OUT_W), .TAG_W(TAG_W)
    ) dut (
        .clk_i      (clk),
        .rstn_i     (rstn),
        .flush_i    (flush),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .mode_i     (mode),
        .data_i     (data_in),
        .tag_i      (tag_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .data_o     (data_out),
        .tag_o      (tag_out),
        .mode_o     (mode_out)
    );

    always #5 clk = ~clk;

    int   checks = 0;
    int   passed = 0;
    int   cyc = 0;
    int   rdy_mode = 0;
    int   n_recv = 0;
    bit   accepted = 1'b0;
    bit   prev_stall = 1'b0;
    bit   snap_out_valid = 1'b0;
    bit   snap_in_ready = 1'b0;
    exp_t prev_out;
    exp_t cur_exp;
    exp_t exp_q[$];
    vec_t vecs[$];

    task automatic chk(input bit ok, input string name, input logic [255:0] act, input logic [255:0] req);
        checks++;
        if (ok) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // Reference Montgomery reduction written with plain integer arithmetic.
    function automatic logic [31:0] mont_ref(input logic m, input logic [63:0] lane);
        longint  a, p;
        int      t, r, a32;
        shortint t16;
        if (!m) begin
            a = $signed(lane);
            p = a * 64'sd58728449;
            t = int'(p);
            r = int'((a - longint'(t) * 64'sd8380417) >>> 32);
        end else begin
            a32 = int'(lane[31:0]);
            t16 = shortint'(a32 * 62209);
            r   = (a32 - int'(t16) * 3329) >>> 16;
        end
        if (CORR && r < 0) r = r + (m ? 3329 : 8380417);
        return r;
    endfunction

    function automatic logic [63:0] rand_lane(input logic m);
        longint x, y;
        if (!m) begin
            x = longint'(int'($urandom));
            y = longint'($urandom_range(2 * 8380416)) - 64'sd8380416;
            return 64'(x * y);
        end
        x = longint'(shortint'($urandom));
        y = longint'($urandom_range(2 * 3328)) - 64'sd3328;
        return {$urandom, 32'(x * y)};
    endfunction

    function automatic vec_t rand_vec(input logic m);
        vec_t v;
        v.mode = m;
        for (int k = 0; k < LANES; k++) begin
            v.din[k*IN_W +: IN_W]   = rand_lane(m);
            v.dexp[k*OUT_W +: OUT_W] = mont_ref(m, v.din[k*IN_W +: IN_W]);
        end
        return v;
    endfunction

    // One clock: sample and score at the falling edge, return just after the rising edge.
    task automatic tick();
        exp_t got;
        case (rdy_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc % 3 == 0);
            default: out_ready = 1'b0;
        endcase
        @(negedge clk);
        snap_out_valid = out_valid;
        snap_in_ready  = in_ready;
        if (prev_stall)
            chk(out_valid && {mode_out, tag_out, data_out} == prev_out, "stall_hold",
                256'({out_valid, mode_out, tag_out, data_out}), 256'({1'b1, prev_out}));
        if (out_valid && out_ready && !flush) begin
            chk(exp_q.size() != 0, "unexpected_out", 256'({mode_out, tag_out, data_out}), 256'(0));
            if (exp_q.size() != 0) begin
                got = exp_q.pop_front();
                chk({mode_out, tag_out, data_out} == got, "result",
                    256'({mode_out, tag_out, data_out}), 256'(got));
                n_recv++;
            end
        end
        accepted = in_valid && in_ready;
        if (flush) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            if (accepted) exp_q.push_back(cur_exp);
            prev_stall = out_valid && !out_ready;
            prev_out   = {mode_out, tag_out, data_out};
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input vec_t v, input logic [TAG_W-1:0] tg);
        int guard = 0;
        in_valid = 1'b1;
        mode     = v.mode;
        data_in  = v.din;
        tag_in   = tg;
        cur_exp  = {v.mode, tg, v.dexp};
        do begin
            tick();
            guard++;
        end while (!accepted && guard < 50);
        chk(accepted, "send_accept", 256'(accepted), 256'(1));
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard = 0;
        while (exp_q.size() != 0 && guard < 300) begin
            tick();
            guard++;
        end
        chk(exp_q.size() == 0, "drain", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t v;
        int   lat, c0, seen, sent;

        // Hand-computed vectors: lanes are {lane3, lane2, lane1, lane0}.
        v.mode = 1'b0;
        v.din  = {64'd0, 64'hFFFF_FFFD_0000_0000, 64'd8380417, 64'h0000_0005_0000_0000};
        v.dexp = {32'd0, (CORR ? 32'd8380414 : 32'hFFFF_FFFD), 32'd0, 32'd5};
        vecs.push_back(v);
        v.mode = 1'b1;
        v.din  = {64'hCAFE_BABE_0000_0000, 64'hFFFF_FFFF_FFFE_0000,
                  64'h1234_5678_0000_0D01, 64'hDEAD_BEEF_0007_0000};
        v.dexp = {32'd0, (CORR ? 32'd3327 : 32'hFFFF_FFFE), 32'd0, 32'd7};
        vecs.push_back(v);
        v.mode = 1'b0;
        v.din  = {64'd70231389093889, 64'h0000_0007_0000_0000,
                  64'hFF80_2000_0000_0000, 64'h007F_E000_0000_0000};
        v.dexp = {32'd0, 32'd7, (CORR ? 32'd1 : 32'hFF80_2000), 32'd8380416};
        vecs.push_back(v);
        v.mode = 1'b1;
        v.din  = {64'd0, 64'hFFFF_FFFF_0000_1A02, 64'h5555_5555_F300_0000, 64'h0000_0000_0D00_0000};
        v.dexp = {32'd0, 32'd0, (CORR ? 32'd1 : 32'hFFFF_F300), 32'd3328};
        vecs.push_back(v);
        for (int i = 0; i < 40; i++) vecs.push_back(rand_vec(1'(i)));

        // Reset values.
        @(negedge clk);
        chk(out_valid == 1'b0, "rst_valid", 256'(out_valid), 256'(0));
        chk(data_out == '0 && tag_out == '0 && mode_out == 1'b0, "rst_payload",
            256'({mode_out, tag_out, data_out}), 256'(0));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rdy_mode = 0;
        tick();
        chk(snap_in_ready && !snap_out_valid, "post_rst", 256'({snap_in_ready, snap_out_valid}), 256'(2));

        // Latency of an isolated Dilithium transaction.
        send(vecs[0], 8'hA5);
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!snap_out_valid && lat < 10);
        chk(lat == 3, "latency", 256'(lat), 256'(3));
        drain();

        // Whole table, alternating modes, downstream ready 1 cycle in 3.
        rdy_mode = 1;
        n_recv   = 0;
        foreach (vecs[i]) send(vecs[i], 8'(i));
        drain();
        chk(n_recv == vecs.size(), "bp_count", 256'(n_recv), 256'(vecs.size()));

        // Random stream at full rate: one acceptance per cycle.
        rdy_mode = 0;
        c0 = cyc;
        for (int i = 0; i < 2000; i++) send(rand_vec(1'($urandom)), 8'(i));
        chk(cyc - c0 == 2000, "throughput", 256'(cyc - c0), 256'(2000));
        drain();

        // Fill all three stages, then flush.
        rdy_mode = 2;
        for (int i = 0; i < 3; i++) send(vecs[i], 8'(8'h10 + i));
        tick();
        chk(!snap_in_ready && snap_out_valid, "full_stall", 256'({snap_in_ready, snap_out_valid}), 256'(1));
        flush = 1'b1;
        in_valid = 1'b1;
        cur_exp = {vecs[3].mode, 8'h1F, vecs[3].dexp};
        data_in = vecs[3].din;
        mode = vecs[3].mode;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        tick();
        chk(!snap_out_valid && snap_in_ready, "flush_clears", 256'({snap_out_valid, snap_in_ready}), 256'(1));

        // An input accepted in the flush cycle must vanish.
        flush = 1'b1;
        in_valid = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        rdy_mode = 0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (snap_out_valid) seen++;
        end
        chk(seen == 0, "flush_drops_input", 256'(seen), 256'(0));
        sent = 0;
        n_recv = 0;
        for (int i = 4; i < 6; i++) begin
            send(vecs[i], 8'(8'h20 + i));
            sent++;
        end
        drain();
        chk(n_recv == sent, "post_flush_count", 256'(n_recv), 256'(sent));

        // Reset in the middle of traffic.
        rdy_mode = 2;
        send(vecs[6], 8'h30);
        send(vecs[7], 8'h31);
        tick();
        rstn = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        chk(!out_valid && in_ready && data_out == '0 && tag_out == '0, "reset_mid",
            256'({out_valid, in_ready, tag_out, data_out}), 256'({1'b0, 1'b1, 8'd0, 128'd0}));
        @(posedge clk);
        #1;
        rstn = 1'b1;
        rdy_mode = 0;
        n_recv = 0;
        send(vecs[1], 8'h40);
        drain();
        chk(n_recv == 1, "post_reset_count", 256'(n_recv), 256'(1));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
